// File: rtl/cmp_max_tracker_pkg.sv
// cmp_track_pkg: shared types and helpers for the cmp_max_tracker slice.
//   state_t  - tracker FSM states (EMPTY: no sample held, TRACK: max valid)
//   cnt_max  - saturation value of an outcome counter of a given width
//              (intended for widths below 32)
package cmp_track_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_t;

  function automatic int unsigned cnt_max(input int unsigned cnt_width);
    return (32'd1 << cnt_width) - 32'd1;
  endfunction

endpackage

// File: rtl/cmp_max_tracker_if.sv
// cmp_max_tracker_if: sample stream plus the comparator loop of cmp_max_tracker.
//   in_valid / in_data / clear      - sample source (master drives)
//   cmp_b                           - stored maximum, fed to comparator b (slave drives)
//   equal / greater / lower         - comparator flags for (in_data, cmp_b)
// The comparator itself lives at the level above and sits on the master side.
interface cmp_max_tracker_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             clear;
  logic [WIDTH-1:0] cmp_b;
  logic             equal;
  logic             greater;
  logic             lower;

  modport master (
    output in_valid, in_data, clear, equal, greater, lower,
    input  cmp_b
  );

  modport slave (
    input  in_valid, in_data, clear, equal, greater, lower,
    output cmp_b
  );

endinterface

// File: rtl/cmp_max_tracker_sat_counter.sv
// sat_counter: outcome counter that sticks at its all-ones value.
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear (takes priority over inc)
//   inc       - count one event this cycle
//   count     - current count
module sat_counter
  import cmp_track_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] SAT = CNT_WIDTH'(cnt_max(CNT_WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cmp_max_tracker.sv
// cmp_max_tracker: running-maximum tracker downstream of an external comparator.
// The stored maximum drives comparator operand b; the returned flags decide
// whether a new sample replaces the maximum and which outcome counter steps.
//   clk, rst                    - clock, asynchronous active-high reset
//   bus (slave)                 - sample stream, clear, comparator loop
//   max_out                     - current maximum (same register as bus.cmp_b)
//   max_valid                   - at least one sample held since reset/clear
//   cnt_greater/equal/lower     - saturating outcome counters
//   upd_valid                   - one-cycle pulse after each accepted sample
//   flag_err                    - sticky: non-one-hot flags on a tracked sample
//   min_out                     - running minimum (only with CMP_TRACK_MIN_EN)
// Optional feature macro: CMP_TRACK_MIN_EN adds the running-minimum register.
module cmp_max_tracker
  import cmp_track_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  cmp_max_tracker_if.slave     bus,
  output logic [WIDTH-1:0]     max_out,
  output logic                 max_valid,
  output logic [CNT_WIDTH-1:0] cnt_greater,
  output logic [CNT_WIDTH-1:0] cnt_equal,
  output logic [CNT_WIDTH-1:0] cnt_lower,
  output logic                 upd_valid,
  output logic                 flag_err
`ifdef CMP_TRACK_MIN_EN
  ,
  output logic [WIDTH-1:0]     min_out
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             upd_d, err_d;
  logic             inc_g, inc_e, inc_l;
  logic             flags_ok;
`ifdef CMP_TRACK_MIN_EN
  logic [WIDTH-1:0] min_q, min_d;
`endif

  assign flags_ok  = $onehot({bus.greater, bus.equal, bus.lower});
  assign max_out   = max_q;
  assign bus.cmp_b = max_q;
  assign max_valid = (state_q == TRACK);
`ifdef CMP_TRACK_MIN_EN
  assign min_out   = min_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      max_q     <= '0;
      upd_valid <= 1'b0;
      flag_err  <= 1'b0;
`ifdef CMP_TRACK_MIN_EN
      min_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      upd_valid <= upd_d;
      flag_err  <= err_d;
`ifdef CMP_TRACK_MIN_EN
      min_q     <= min_d;
`endif
    end
  end

  // Clear beats a coincident sample. The first sample after EMPTY is loaded
  // unconditionally because cmp_b is not yet meaningful. A sample with bad
  // flags is still acknowledged (upd_valid) but changes neither max nor counts.
  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    upd_d   = 1'b0;
    err_d   = flag_err;
    inc_g   = 1'b0;
    inc_e   = 1'b0;
    inc_l   = 1'b0;
`ifdef CMP_TRACK_MIN_EN
    min_d   = min_q;
`endif
    if (bus.clear) begin
      state_d = EMPTY;
      max_d   = '0;
      err_d   = 1'b0;
`ifdef CMP_TRACK_MIN_EN
      min_d   = '0;
`endif
    end else if (bus.in_valid) begin
      upd_d = 1'b1;
      case (state_q)
        EMPTY: begin
          state_d = TRACK;
          max_d   = bus.in_data;
`ifdef CMP_TRACK_MIN_EN
          min_d   = bus.in_data;
`endif
        end
        TRACK: begin
          if (!flags_ok) begin
            err_d = 1'b1;
          end else if (bus.greater) begin
            max_d = bus.in_data;
            inc_g = 1'b1;
          end else if (bus.equal) begin
            inc_e = 1'b1;
          end else begin
            inc_l = 1'b1;
          end
`ifdef CMP_TRACK_MIN_EN
          if (bus.in_data < min_q) begin
            min_d = bus.in_data;
          end
`endif
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_greater (
    .clk(clk), .rst(rst), .clr(bus.clear), .inc(inc_g), .count(cnt_greater)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_equal (
    .clk(clk), .rst(rst), .clr(bus.clear), .inc(inc_e), .count(cnt_equal)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_lower (
    .clk(clk), .rst(rst), .clr(bus.clear), .inc(inc_l), .count(cnt_lower)
  );

endmodule

// File: doc/cmp_max_tracker.md
# cmp_max_tracker

Running-maximum tracker placed directly downstream of `comparator`. It drives the comparator's `b` operand with the stored maximum. The upstream sample goes to `a`. The block consumes `equal`/`greater`/`lower` to update the maximum and to keep saturating outcome counters. It turns the purely combinational comparator into a stateful peak detector for sample streams.

## Interface
- `WIDTH`, 4: sample width in bits, unsigned; must match the comparator's `WIDTH`.
- `CNT_WIDTH`, 8: width of each outcome counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample present on `in_data` this cycle.
- `in_data`  in  WIDTH  sample; also wired externally to comparator `a`.
- `clear`  in  1  synchronous restart of tracking.
- `cmp_b`  out  WIDTH  stored maximum; drives comparator `b`.
- `equal`, `greater`, `lower`  in  1 each  comparator flags for (`in_data`, `cmp_b`).
- `max_out`  out  WIDTH  current maximum (same register as `cmp_b`).
- `max_valid`  out  1  at least one sample accepted since reset/clear.
- `cnt_greater`, `cnt_equal`, `cnt_lower`  out  CNT_WIDTH each  saturating outcome counts.
- `upd_valid`  out  1  one-cycle pulse after each accepted sample.
- `flag_err`  out  1  sticky: flags not one-hot on an accepted sample.
- `min_out`  out  WIDTH  running minimum; present only with `CMP_TRACK_MIN_EN`.

## Operation
- Two-state FSM: `EMPTY`, `TRACK`.
- Reset: state `EMPTY`. All outputs are 0: `cmp_b`, `max_out`, `max_valid`, counters, `upd_valid`, `flag_err`, `min_out`.
- `EMPTY` + `in_valid`:
  - load `max` (and `min`) with `in_data` and ignore the flags;
  - no counter changes;
  - go to `TRACK`; `max_valid` becomes 1.
- `TRACK` + `in_valid`:
  - `greater`: `max` <= `in_data`; `cnt_greater` increments.
  - `equal`: `max` unchanged; `cnt_equal` increments.
  - `lower`: `max` unchanged; `cnt_lower` increments.
- Flag check in `TRACK`: if the flags are not exactly one-hot, set `flag_err` (sticky until reset/clear). `max` and all counters stay unchanged.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- `clear`:
  - returns to `EMPTY`;
  - zeroes `max`, `min`, counters, `max_valid` and `flag_err`;
  - `upd_valid` is 0 next cycle.
- `clear` and `in_valid` together: `clear` wins and the sample is dropped.
- No valid sample: all state holds; flags are don't-care.

## Timing
- Flags are combinational from `in_data`/`cmp_b`. They are sampled at the same edge as `in_valid`.
- `max_out`/`cmp_b`, the counters and `min_out` update one cycle after an accepted sample (latency 1).
- `upd_valid` is high in that same following cycle only.
- Back-to-back samples are accepted every cycle. Each sample compares against the maximum as updated by the previous sample.
- Asserting `rst` mid-stream forces the reset values immediately, without waiting for a clock edge. Tracking resumes in `EMPTY` after release.

## Configuration
- `CMP_TRACK_MIN_EN` defined:
  - adds the `min_out` port and min register, using an internal `in_data < min` compare;
  - updates on the same cycle as `max`;
  - loaded on the first sample and cleared by `clear`/`rst`.
- Undefined: no `min_out` port and no min logic; all other behaviour is identical.

## Structure
- Package `cmp_track_pkg`:
  - state enum `{EMPTY, TRACK}`;
  - function `cnt_max(CNT_WIDTH)` returning the saturation value.
- Sub-module `sat_counter` (parameter `CNT_WIDTH`; inputs `inc` and synchronous `clr`), instantiated three times.
- The comparator is not instantiated inside. It is connected alongside this block at the level above.

## Test plan
- First sample: WIDTH=4, reset, drive 5 -> next cycle `max_out`=5, `max_valid`=1, `upd_valid`=1, all counters 0.
- Mixed stream: 5, 9, 9, 3, 12 -> `max_out`=12, `cnt_greater`=2, `cnt_equal`=1, `cnt_lower`=1. With `CMP_TRACK_MIN_EN`, `min_out`=3.
- Saturation: CNT_WIDTH=2, six increasing samples 1..6 -> `cnt_greater`=3 (held, not wrapped).
- Clear priority: `clear`=1 with `in_valid`=1 and data 15 -> next cycle `max_valid`=0, `max_out`=0, counters 0, `upd_valid`=0.
- Flag fault: in `TRACK`, force `greater`=`lower`=1 -> `flag_err`=1, `max_out` and counters unchanged. `flag_err` stays high until `clear`.
- Async reset: assert `rst` between clock edges mid-stream -> all outputs 0 before the next edge. The first sample after release reloads `max`.
